// File: rtl/gsim_x_collector_if.sv
// gsim_x_collector_if: solver word input plus ready/valid replay stream and status flags.
// master is the collector side, slave is the producer/consumer side.
interface gsim_x_collector_if #(
  parameter int N     = 16,
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  localparam int IW = $clog2(N);
  logic             in_valid;
  logic [IN_W-1:0]  x_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             out_sat;
  logic             frame_done;
  logic             ovf_err;
  modport master (
    input  in_valid, x_in, out_ready,
    output out_valid, out_data, out_idx, out_last, out_sat, frame_done, ovf_err
  );
  modport slave (
    output in_valid, x_in, out_ready,
    input  out_valid, out_data, out_idx, out_last, out_sat, frame_done, ovf_err
  );
endinterface

// File: rtl/gsim_x_collector.sv
// gsim_x_collector: buffers one N-word solver frame, replays it as a saturating narrowed stream.
// Define GSIM_XCOL_ROUND_EN for round-half-up before the shift; default truncates.
module gsim_x_collector #(
  parameter int N         = 16,
  parameter int IN_W      = 32,
  parameter int OUT_W     = 16,
  parameter int FRAC_DROP = 8
) (
  input logic              clk,
  input logic              reset,
  gsim_x_collector_if.master bus
);
  localparam int IW = $clog2(N);
`ifdef GSIM_XCOL_ROUND_EN
  localparam logic signed [IN_W:0] BIAS = {{IN_W{1'b0}}, 1'b1} << (FRAC_DROP - 1);
`else
  localparam logic signed [IN_W:0] BIAS = '0;
`endif
  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t              state, state_nx;
  logic [IN_W-1:0]     mem [N];
  logic [IW-1:0]       wr_idx, rd_idx;
  logic                wr_en, wr_last, rd_last, hs;
  logic                frame_done_q, ovf_err_q;
  logic [IN_W-1:0]     rd_word;
  logic signed [IN_W:0] ext, shr;
  logic                fits;
  logic [OUT_W-1:0]    conv;
  assign wr_en   = state == COLLECT && bus.in_valid;
  assign wr_last = wr_idx == IW'(N - 1);
  assign rd_last = rd_idx == IW'(N - 1);
  assign hs      = state == DRAIN && bus.out_ready;
  // Conversion works on the raw stored word so the write path stays a plain register file.
  assign rd_word = mem[rd_idx];
  assign ext     = $signed({rd_word[IN_W-1], rd_word}) + BIAS;
  assign shr     = ext >>> FRAC_DROP;
  assign fits    = (&shr[IN_W:OUT_W-1]) | ~(|shr[IN_W:OUT_W-1]);
  assign conv    = fits ? shr[OUT_W-1:0] : {shr[IN_W], {(OUT_W-1){~shr[IN_W]}}};
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= COLLECT;
    else        state <= state_nx;
  always_comb
    state_nx = state == COLLECT ? ((wr_en && wr_last) ? DRAIN : COLLECT)
                                : ((hs && rd_last) ? COLLECT : DRAIN);
  always_comb begin
    bus.out_valid  = state == DRAIN;
    bus.out_data   = state == DRAIN ? conv : '0;
    bus.out_idx    = state == DRAIN ? rd_idx : '0;
    bus.out_last   = state == DRAIN && rd_last;
    bus.out_sat    = state == DRAIN && !fits;
    bus.frame_done = frame_done_q;
    bus.ovf_err    = ovf_err_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_idx       <= '0;
      rd_idx       <= '0;
      frame_done_q <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      wr_idx       <= wr_en ? (wr_last ? '0 : wr_idx + 1'b1) : wr_idx;
      rd_idx       <= hs ? (rd_last ? '0 : rd_idx + 1'b1) : rd_idx;
      frame_done_q <= hs && rd_last;
      ovf_err_q    <= ovf_err_q | (state == DRAIN && bus.in_valid);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= bus.x_in;
endmodule

// File: tb/tb_gsim_x_collector.sv
// tb_gsim_x_collector: directed frames with a scoreboard of expected beats built from an arithmetic model.
module tb_gsim_x_collector;
  typedef struct packed {logic [15:0] d; logic [3:0] i; logic l; logic s;} beat_t;
  logic clk = 0;
  logic reset;
  int errors = 0;
  int checks = 0;
  beat_t q[$];
  logic [31:0] fr[16];
  gsim_x_collector_if #(.N(16), .IN_W(32), .OUT_W(16)) bus ();
  gsim_x_collector #(.N(16), .IN_W(32), .OUT_W(16), .FRAC_DROP(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic beat_t model(input logic [31:0] x, input int i);
    longint v = longint'($signed(x));
    beat_t b;
`ifdef GSIM_XCOL_ROUND_EN
    v = v + 128;
`endif
    v = v >>> 8;
    b.i = 4'(i);
    b.l = (i == 15);
    if (v > 32767) begin b.d = 16'h7FFF; b.s = 1'b1; end
    else if (v < -32768) begin b.d = 16'h8000; b.s = 1'b1; end
    else begin b.d = 16'(v); b.s = 1'b0; end
    return b;
  endfunction
  task automatic send(input logic [31:0] w[16], input bit gaps);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gaps && i % 3 == 1) begin
        bus.in_valid = 0;
        @(negedge clk);
      end
      chk("collect_valid", bus.out_valid, 0);
      bus.in_valid = 1;
      bus.x_in = w[i];
      q.push_back(model(w[i], i));
    end
  endtask
  task automatic drain(input bit bp, input bit inject, input int stop_at);
    int hs = 0;
    int cyc = 0;
    bit stalled = 0;
    beat_t prev, e, cur;
    while (hs < 16 && cyc < 200) begin
      @(negedge clk);
      bus.in_valid = inject;
      bus.x_in = 32'h1234_0000;
      bus.out_ready = !bp || (cyc % 4 == 0) || (cyc % 4 == 3);
      cyc++;
      cur = {bus.out_data, bus.out_idx, bus.out_last, bus.out_sat};
      chk("valid", bus.out_valid, 1);
      if (stalled) chk("hold_beat", 32'(cur), 32'(prev));
      if (bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL extra_beat observed=%h expected=none", cur);
        end else begin
          e = q.pop_front();
          chk("data", cur.d, e.d);
          chk("idx", cur.i, e.i);
          chk("last", cur.l, e.l);
          chk("sat", cur.s, e.s);
        end
        hs++;
      end
      stalled = !bus.out_ready;
      prev = cur;
      if (stop_at != 0 && hs == stop_at) return;
    end
    chk("handshakes", hs, 16);
    @(negedge clk);
    bus.in_valid = 0;
    bus.out_ready = 0;
    chk("frame_done", bus.frame_done, 1);
    chk("valid_after", bus.out_valid, 0);
    @(negedge clk);
    chk("done_pulse", bus.frame_done, 0);
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_data"}, bus.out_data, 0);
    chk({tag, "_idx"}, bus.out_idx, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_sat"}, bus.out_sat, 0);
    chk({tag, "_done"}, bus.frame_done, 0);
    chk({tag, "_ovf"}, bus.ovf_err, 0);
  endtask
  initial begin
    reset = 0;
    bus.in_valid = 0;
    bus.x_in = 0;
    bus.out_ready = 0;
    #1 chk_idle("rst");
    repeat (2) @(negedge clk);
    reset = 1;
    for (int i = 0; i < 16; i++) fr[i] = 32'h0001_8000;
    send(fr, 0);
    drain(0, 0, 0);
    chk("ovf_clean", bus.ovf_err, 0);
    fr[0] = 32'h0000_0080; fr[1] = 32'hFFFF_FF80; fr[2] = 32'h7FFF_0000; fr[3] = 32'h8000_0000;
    fr[4] = 32'h007F_FF00; fr[5] = 32'hFFFF_0000; fr[6] = 32'h007F_FF80; fr[7] = 32'hFF80_0000;
    fr[8] = 32'hFF7F_FFFF;
    for (int i = 9; i < 16; i++) fr[i] = $urandom;
    send(fr, 1);
    drain(1, 0, 0);
    for (int i = 0; i < 16; i++) fr[i] = $urandom;
    send(fr, 0);
    drain(0, 1, 0);
    chk("ovf_set", bus.ovf_err, 1);
    for (int i = 0; i < 16; i++) fr[i] = $urandom_range(32'h00FF_FFFF, 0) - 32'h0080_0000;
    send(fr, 1);
    drain(1, 0, 0);
    chk("ovf_sticky", bus.ovf_err, 1);
    for (int i = 0; i < 16; i++) fr[i] = $urandom;
    send(fr, 0);
    drain(0, 0, 5);
    #2 reset = 0;
    #1 chk_idle("mid_rst");
    q.delete();
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 16; i++) fr[i] = 32'h0010_0000 + (i << 16);
    send(fr, 0);
    drain(0, 0, 0);
    chk("q_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gsim_x_collector.md
# gsim_x_collector

Downstream stage of the Gauss-Seidel solver. It captures the 16-word solution burst (`x_out`/`out_valid`, Q16.16 signed) produced by the solver top level. It converts each word to a narrower signed fixed-point format with saturation, then replays the frame over a ready/valid stream so a slower consumer can take it at its own pace. The solver has no backpressure, so this block is the decoupling buffer between the solver and the system bus.

## Interface
- `N`, 16, words per frame (solution vector length); index counters are `$clog2(N)` bits
- `IN_W`, 32, input word width (Q16.16 signed)
- `OUT_W`, 16, output word width (signed)
- `FRAC_DROP`, 8, LSBs removed in conversion; default maps Q16.16 to Q8.8
- `clk`  in  1  clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input word strobe (driven by solver `out_valid`)
- `x_in`  in  IN_W  input word (driven by solver `x_out`)
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  consumer accepts beat
- `out_data`  out  OUT_W  converted word
- `out_idx`  out  $clog2(N)  element index of current beat
- `out_last`  out  1  high on beat with `out_idx == N-1`
- `out_sat`  out  1  current beat was clipped
- `frame_done`  out  1  one-cycle pulse after the final beat handshakes
- `ovf_err`  out  1  sticky: input word arrived while draining

## Operation
- Storage: N x IN_W register array holding raw input words. Conversion is applied on the read side.
- States: `COLLECT` (reset state) and `DRAIN`.
- `COLLECT`:
  - On each cycle with `in_valid`, write `x_in` to `buf[wr_idx]` and increment `wr_idx`.
  - When the word written has `wr_idx == N-1`, go to `DRAIN` next cycle with `wr_idx` reset to 0.
  - `out_valid` = 0.
- `DRAIN`:
  - `out_valid` = 1; `out_data`/`out_sat` are the conversion of `buf[rd_idx]`; `out_idx` = `rd_idx`.
  - On handshake (`out_valid && out_ready`), increment `rd_idx`.
  - On handshake with `rd_idx == N-1`: `rd_idx` goes to 0, state goes to `COLLECT`, and `frame_done` pulses the next cycle.
- Input during `DRAIN`, including the final-handshake cycle: the word is dropped, `ovf_err` is set, and the buffer is unchanged. `ovf_err` clears only on reset.
- Conversion:
  - Sign-extend `x_in` to IN_W+1 bits.
  - Apply the optional rounding bias (see Configuration).
  - Arithmetic right shift by FRAC_DROP.
  - If the result is > 2^(OUT_W-1)-1, output `0x7FFF`; if < -2^(OUT_W-1), output `0x8000`. `out_sat` = 1 on either clip.
- Gaps in `in_valid` within a frame are legal: collection simply waits.
- `out_data`, `out_idx`, `out_last` and `out_sat` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - state = `COLLECT`; `wr_idx` = `rd_idx` = 0.
  - `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `out_sat` = 0, `frame_done` = 0, `ovf_err` = 0.
  - Buffer contents are not reset.
- When not in `DRAIN`, `out_data`, `out_idx`, `out_last` and `out_sat` are forced to 0.
- Latency: the N-th input word is written at edge t. `out_valid` rises after edge t and is visible in cycle t+1.
- Output conversion is combinational from registered `buf` and `rd_idx`; there are no combinational paths from `in_valid`/`x_in` to outputs.
- Throughput: with `out_ready` held high, N beats take N consecutive cycles. Total frame turnaround is 2N cycles plus consumer stall.
- `frame_done` is registered: high for exactly the one cycle after the last handshake. That cycle is already in `COLLECT`.
- Reset asserted mid-frame (either state):
  - All counters, state and flags clear immediately and asynchronously.
  - The partial frame is discarded and `out_valid` drops without completing a handshake.

## Configuration
- `GSIM_XCOL_ROUND_EN` defined: before the shift, add 2^(FRAC_DROP-1). This is round-half-up. Saturation is evaluated after rounding.
- Not defined: no bias; plain arithmetic shift, i.e. truncation toward -infinity.

## Test plan
- Conversion, exact value: frame of 16 words, all 0x0001_8000 (1.5), `out_ready`=1 -> 16 beats of 0x0180 with `out_idx` 0..15, `out_last` only on idx 15, `out_sat`=0, `frame_done` pulse the cycle after, back-to-back beats.
- Rounding: word 0x0000_0080 -> 0x0000 without the macro, 0x0001 with it. Word 0xFFFF_FF80 -> 0xFFFF without the macro, 0x0000 with it.
- Saturation: 0x7FFF_0000 -> 0x7FFF with `out_sat`=1; 0x8000_0000 -> 0x8000 with `out_sat`=1; 0x007F_FF00 -> 0x7FFF with `out_sat`=0.
- Backpressure: toggle `out_ready` 1,0,0,1 repeatedly -> data, index and flags stay stable while stalled, no beat is lost or duplicated, 16 handshakes total.
- Overflow: assert `in_valid` with 0x1234_0000 during `DRAIN` -> `ovf_err`=1 and sticky, replayed frame unchanged. Next frame collects normally.
- Reset mid-drain: assert `reset` low at beat 5 -> `out_valid`=0 immediately and all outputs at reset values. A fresh 16-word frame then drains from idx 0.
